// File: rtl/ifb_pkg.sv
// ifb_pkg: shared widths, PC step and the FIFO entry type for the
// instruction prefetch buffer (ifetch_buffer and ifb_fifo).
package ifb_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } ifb_entry_t;
endpackage

// File: rtl/ifb_fifo.sv
// ifb_fifo: synchronous FIFO of {instr, pc} entries.
// Pointers carry one extra MSB so full and empty are distinguishable.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   i_flush          drop all entries; wins over push/pop
//   i_push, i_wdata  write one entry
//   i_pop            retire head entry (caller guarantees non-empty)
//   o_rdata          head entry (combinational)
//   o_empty, o_count occupancy
module ifb_fifo
  import ifb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_push,
  input  ifb_entry_t i_wdata,
  input  logic       i_pop,
  output ifb_entry_t o_rdata,
  output logic       o_empty,
  output logic [AW:0] o_count
);
  logic [AW:0] r_wr, r_rd;
  ifb_entry_t  r_mem [DEPTH];

  assign o_count = r_wr - r_rd;
  assign o_empty = (r_wr == r_rd);
  assign o_rdata = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // When full, push+pop writes the slot being read this cycle; the head is
  // consumed before the edge, so the overwrite is safe.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_wdata;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_flush && !i_pop && (o_count == (AW+1)'(DEPTH))));
`endif
endmodule

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: prefetch stage between instruction memory and decode.
// Sequences fetch_pc, issues one word read per cycle when credit allows,
// queues {instr, pc} in ifb_fifo and presents the head to decode.
// A pc_update flushes the queue, redirects fetch and toggles the epoch so
// any response tagged with the old epoch is discarded.
// Optional: define IFB_STATS_EN to add saturating flush_cnt / stall_cnt.
// Ports:
//   clk, rst                     clock, async active-low reset
//   imem_req/imem_addr           read request to instruction memory
//   imem_rdata/imem_valid        response, one cycle after the request
//   pc_update/pc_new             redirect from write-back
//   dec_valid/dec_ready          decode handshake
//   ir_o, PC, npc                head instruction, its address, PC+4
//   flush_cnt, stall_cnt         (IFB_STATS_EN only) event counters
module ifetch_buffer
  import ifb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               pc_update,
  input  logic [PC_W-1:0]    pc_new,
  input  logic               dec_ready,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] ir_o,
  output logic [PC_W-1:0]    PC,
  output logic [PC_W-1:0]    npc
`ifdef IFB_STATS_EN
  ,
  output logic [15:0]        flush_cnt,
  output logic [15:0]        stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [PC_W-1:0] r_fetch_pc, r_tag_addr;
  logic            r_epoch, r_tag_epoch, r_outstanding;
  logic [AW:0]     w_count;
  logic [AW+1:0]   w_credit;
  logic            w_empty, w_issue, w_push, w_pop;
  ifb_entry_t      w_head, w_wdata;
  logic            w_unused;

  assign w_unused = &{1'b0, pc_new[1:0]};

  // An outstanding request will land next edge, so it already holds a slot.
  assign w_credit = {1'b0, w_count} + {{(AW+1){1'b0}}, r_outstanding};
  assign w_issue  = rst && !pc_update && (w_credit < (AW+2)'(DEPTH));

  assign imem_req  = w_issue;
  assign imem_addr = r_fetch_pc;

  assign w_push  = imem_valid && r_outstanding && (r_tag_epoch == r_epoch) && !pc_update;
  assign w_pop   = dec_valid && dec_ready && !pc_update;
  assign w_wdata = '{instr: imem_rdata, pc: r_tag_addr};

  ifb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_flush (pc_update),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Outputs are forced to zero while empty so stale slots never leak out.
  assign dec_valid = !w_empty;
  assign ir_o      = w_empty ? '0 : w_head.instr;
  assign PC        = w_empty ? '0 : w_head.pc;
  assign npc       = PC + PC_STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_epoch       <= 1'b0;
      r_outstanding <= 1'b0;
      r_tag_epoch   <= 1'b0;
      r_tag_addr    <= '0;
    end else if (pc_update) begin
      r_fetch_pc    <= {pc_new[PC_W-1:2], 2'b00};
      r_epoch       <= ~r_epoch;
      r_outstanding <= 1'b0;
    end else begin
      r_outstanding <= w_issue;
      if (w_issue) begin
        r_fetch_pc  <= r_fetch_pc + PC_STEP;
        r_tag_addr  <= r_fetch_pc;
        r_tag_epoch <= r_epoch;
      end
    end
  end

`ifdef IFB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (pc_update && (flush_cnt != 16'hFFFF))                stall_cnt <= stall_cnt;
      if (pc_update && (flush_cnt != 16'hFFFF))                flush_cnt <= flush_cnt + 16'd1;
      if (dec_valid && !dec_ready && (stall_cnt != 16'hFFFF))  stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: directed bench for ifetch_buffer. A queue-based model of
// the prefetch buffer is checked against the DUT on every falling edge, and
// hand-computed literals pin the key cycles. A second instance with
// RESET_PC=FFFF_FFF8 covers address wrap.
module tb_ifetch_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, pc_update, dec_ready, stray;
  logic [31:0] pc_new;
  logic        imem_req, imem_valid, dec_valid;
  logic [31:0] imem_addr, imem_rdata, ir_o, PC, npc;
  logic        imem_req2, imem_valid2, dec_valid2;
  logic [31:0] imem_addr2, imem_rdata2, ir_o2, PC2, npc2;
`ifdef IFB_STATS_EN
  logic [15:0] flush_cnt, stall_cnt, flush_cnt2, stall_cnt2;
`endif

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .pc_update(pc_update),
    .pc_new(pc_new), .dec_ready(dec_ready), .dec_valid(dec_valid),
    .ir_o(ir_o), .PC(PC), .npc(npc)
`ifdef IFB_STATS_EN
    , .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
`endif
  );

  ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .imem_valid(imem_valid2), .pc_update(1'b0),
    .pc_new(32'h0), .dec_ready(1'b1), .dec_valid(dec_valid2),
    .ir_o(ir_o2), .PC(PC2), .npc(npc2)
`ifdef IFB_STATS_EN
    , .flush_cnt(flush_cnt2), .stall_cnt(stall_cnt2)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a >> 2;
  endfunction

  // Instruction memories: one-cycle read latency, unaware of reset.
  logic        r_mv = 1'b0, r_mv2 = 1'b0;
  logic [31:0] r_rd = '0, r_rd2 = '0;
  always @(posedge clk) begin
    r_mv  <= imem_req;  r_rd  <= mem_word(imem_addr);
    r_mv2 <= imem_req2; r_rd2 <= mem_word(imem_addr2);
  end
  assign imem_valid  = r_mv | stray;
  assign imem_rdata  = stray ? 32'hDEAD_BEEF : r_rd;
  assign imem_valid2 = r_mv2;
  assign imem_rdata2 = r_rd2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_fetch, m_out_addr;
  bit          m_out, m_epoch, m_tag_epoch;

  always @(negedge clk) begin
    bit exp_req;
    if (!rst) begin
      mq.delete();
      m_fetch = 32'h0; m_out = 0; m_epoch = 0; m_tag_epoch = 0; m_out_addr = 0;
    end else begin
      exp_req = !pc_update && ((mq.size() + int'(m_out)) < DEPTH);
      chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_fetch);
      chk("dec_valid", {31'b0, dec_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("ir_o", ir_o, mq[0].instr);
        chk("PC", PC, mq[0].pc);
        chk("npc", npc, mq[0].pc + 32'd4);
      end
      if (pc_update) begin
        mq.delete();
        m_fetch = {pc_new[31:2], 2'b00};
        m_epoch = ~m_epoch;
        m_out   = 0;
      end else begin
        if (dec_ready && mq.size() != 0) void'(mq.pop_front());
        if (imem_valid && m_out && (m_tag_epoch == m_epoch))
          mq.push_back('{instr: mem_word(m_out_addr), pc: m_out_addr});
        if (exp_req) begin
          m_out_addr  = m_fetch;
          m_tag_epoch = m_epoch;
          m_fetch     = m_fetch + 32'd4;
        end
        m_out = exp_req;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int nreq;
    rst = 0; pc_update = 0; pc_new = 0; dec_ready = 1; stray = 0;
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_ir_o", ir_o, 32'h0);
    chk("rst_PC", PC, 32'h0);
    chk("rst_npc", npc, 32'h4);
    step(); step();

    // Streaming with dec_ready=1; dut2 wraps through FFFF_FFFC.
    rst = 1;
    #1 chk("c0_addr", imem_addr, 32'h0); chk("wrap_a0", imem_addr2, 32'hFFFF_FFF8);
    step();
    #1 chk("c1_addr", imem_addr, 32'h4); chk("wrap_a1", imem_addr2, 32'hFFFF_FFFC);
    step();
    #1 chk("wrap_a2", imem_addr2, 32'h0);
    chk("c2_valid", {31'b0, dec_valid}, 32'd1);
    chk("c2_ir", ir_o, 32'h0); chk("c2_PC", PC, 32'h0); chk("c2_npc", npc, 32'h4);
    chk("wrap_pc0", PC2, 32'hFFFF_FFF8);
    step();
    #1 chk("c3_PC", PC, 32'h4); chk("c3_ir", ir_o, 32'h1);
    chk("wrap_pc1", PC2, 32'hFFFF_FFFC); chk("wrap_npc1", npc2, 32'h0);
    step();
    #1 chk("wrap_pc2", PC2, 32'h0);
    repeat (6) step();

    // Redirect to 0x200 with decode stalled: exactly DEPTH requests issue.
    pc_update = 1; pc_new = 32'h200; dec_ready = 0;
    #1 chk("redir_noreq", {31'b0, imem_req}, 32'd0);
    step(); pc_update = 0; nreq = 0;
    for (int i = 0; i < 10; i++) begin
      #1 if (imem_req) nreq++;
      step();
    end
    chk("stall_nreq", nreq, 32'd4);
    chk("stall_noreq", {31'b0, imem_req}, 32'd0);
    chk("stall_head_PC", PC, 32'h200);
    chk("stall_head_ir", ir_o, 32'h80);
    dec_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_PC", PC, 32'h200 + 32'(4 * i));
      step();
    end
    repeat (4) step();

    // Redirect with 3 queued entries and one request in flight.
    rst = 0; dec_ready = 0; step(); rst = 1;
    repeat (4) step();
    #1 chk("pre_redir_valid", {31'b0, dec_valid}, 32'd1);
    pc_update = 1; pc_new = 32'h0000_0103;
    #1 chk("redir2_noreq", {31'b0, imem_req}, 32'd0);
    step(); pc_update = 0;
    #1 chk("post_redir_valid", {31'b0, dec_valid}, 32'd0);
    chk("post_redir_addr", imem_addr, 32'h100);
    dec_ready = 1;
    step(); step();
    #1 chk("redir_first_PC", PC, 32'h100); chk("redir_first_ir", ir_o, 32'h40);

    // Back-to-back redirects: the last one wins.
    pc_update = 1; pc_new = 32'h300; step();
    pc_new = 32'h404; step(); pc_update = 0;
    step(); step();
    #1 chk("b2b_PC", PC, 32'h404);
    repeat (3) step();

    // Asynchronous reset mid-operation with a response in flight.
    dec_ready = 0; step(); step();
    #1 chk("pre_rst_valid", {31'b0, dec_valid}, 32'd1);
    rst = 0;
    #1 chk("arst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("arst_dec_valid", {31'b0, dec_valid}, 32'd0);
    chk("arst_ir_o", ir_o, 32'h0);
    chk("arst_PC", PC, 32'h0);
    chk("arst_npc", npc, 32'h4);
    step();
    rst = 1; stray = 1; dec_ready = 1;
    #1 chk("restart_addr", imem_addr, 32'h0);
    step(); stray = 0;
    step();
    #1 chk("restart_ir", ir_o, 32'h0); chk("restart_PC", PC, 32'h0);
    repeat (3) step();

`ifdef IFB_STATS_EN
    rst = 0; step(); rst = 1; dec_ready = 1;
    repeat (4) step();
    for (int i = 0; i < 3; i++) begin
      pc_update = 1; pc_new = 32'h1000; step();
      pc_update = 0; repeat (3) step();
    end
    repeat (2) step();
    dec_ready = 0; repeat (5) step();
    dec_ready = 1;
    #1 chk("flush_cnt", {16'h0, flush_cnt}, 32'd3);
    chk("stall_cnt", {16'h0, stall_cnt}, 32'd5);
    repeat (3) step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
